pe_mmio_decoder: RTL and testbench

- Parametrised memory-mapped I/O decoder and read-return stage between the RS5 data port and the PE peripherals: data memory, RTC, PLIC, DMNI, debug and future slots.
- Generalises the fixed one-cycle decode to N one-hot address windows.
- Each slave has its own configurable read latency; the block stalls the core while a read is outstanding.
- Unmapped accesses are trapped with a sticky error flag and a captured address.

---
 rtl/pe_mmio_decoder.sv | 121 ++++++++++++
 tb/tb_pe_mmio_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pe_mmio_decoder.sv
// MMIO decoder: one-hot address windows onto N_SLV slaves with a per-slave read latency,
// a core stall while a read is outstanding, and a sticky trap for unmapped accesses.
module pe_mmio_decoder #(
  parameter int                            N_SLV   = 4,
  parameter int                            LAT_W   = 2,
  parameter logic [N_SLV-1:0][LAT_W-1:0]   SLV_LAT = {N_SLV{LAT_W'(1)}}
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cpu_en_i,
  input  logic [3:0]             cpu_we_i,
  input  logic [31:0]            cpu_addr_i,
  output logic [31:0]            cpu_data_o,
  output logic                   stall_o,
  output logic [N_SLV-1:0]       slv_en_o,
  input  logic [N_SLV-1:0][31:0] slv_data_i,
  output logic                   err_o,
  output logic [31:0]            err_addr_o,
  input  logic                   err_clr_i
);

  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             rd_bad_q, rd_bad_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [N_SLV-1:0] hit;
  logic [SEL_W-1:0] hit_idx;
  logic [LAT_W-1:0] hit_lat;
  logic             accept;
  logic             is_rd;

  // A configured latency of 0 behaves as a single-cycle slave.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    hit_lat = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (cpu_addr_i[31:24] == 8'(1 << i)) begin
        hit[i]  = 1'b1;
        hit_idx = SEL_W'(i);
        hit_lat = SLV_LAT[i];
      end
    end
    if (hit_lat == '0) hit_lat = LAT_W'(1);
  end

  // Gating with rst_ni keeps the combinational outputs quiet while reset is held.
  assign accept   = rst_ni && cpu_en_i && (state_q == IDLE);
  assign is_rd    = ~|cpu_we_i;
  assign slv_en_o = accept ? hit : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    rd_bad_d   = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    if (state_q == WAIT) begin
      if (cnt_q == LAT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end

    if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end

    if (accept) begin
      if (hit == '0) begin
        // A fresh trap beats a simultaneous clear; otherwise the first address is held.
        err_d    = 1'b1;
        rd_bad_d = is_rd;
        if (!err_q || err_clr_i) err_addr_d = cpu_addr_i;
      end else if (is_rd) begin
        sel_d = hit_idx;
        if (hit_lat != LAT_W'(1)) begin
          state_d = WAIT;
          cnt_d   = hit_lat - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      rd_bad_q   <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      rd_bad_q   <= rd_bad_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign stall_o    = (state_q == WAIT);
  assign cpu_data_o = (!rst_ni || rd_bad_q) ? 32'h0 : slv_data_i[sel_q];
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_pe_mmio_decoder.sv
// Bench for pe_mmio_decoder: transaction-level model checked every cycle plus directed literal checks.
module tb_pe_mmio_decoder;
  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cpu_en_i;
  logic [3:0]        cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_data_o;
  logic              stall_o;
  logic [N-1:0]      slv_en_o;
  logic [N-1:0][31:0] slv_data_i;
  logic              err_o;
  logic [31:0]       err_addr_o;
  logic              err_clr_i;

  always #5 clk_i = ~clk_i;

  pe_mmio_decoder #(
    .N_SLV  (N),
    .LAT_W  (2),
    .SLV_LAT({2'd3, 2'd1, 2'd1, 2'd1})
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .cpu_en_i  (cpu_en_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_o(cpu_data_o),
    .stall_o   (stall_o),
    .slv_en_o  (slv_en_o),
    .slv_data_i(slv_data_i),
    .err_o     (err_o),
    .err_addr_o(err_addr_o),
    .err_clr_i (err_clr_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Address map and read latencies written out by hand.
  logic [7:0] win_tab [N] = '{8'h01, 8'h02, 8'h04, 8'h08};
  int         lat_tab [N] = '{1, 1, 1, 3};

  function automatic int slot(input logic [31:0] a);
    for (int i = 0; i < N; i++) if (a[31:24] == win_tab[i]) return i;
    return -1;
  endfunction

  // Model: cycle index, first cycle a new request may be accepted, and the cycle that returns 0.
  int          mcyc   = 0;
  int          m_free = 0;
  int          m_zero = -1;
  int          m_sel  = 0;
  int          m_s    = 0;
  logic        m_err  = 1'b0;
  logic [31:0] m_eaddr = 32'h0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcyc = 0; m_free = 0; m_zero = -1; m_sel = 0; m_err = 1'b0; m_eaddr = 32'h0;
    end else begin
      m_s = slot(cpu_addr_i);
      if (cpu_en_i && mcyc >= m_free && m_s < 0) begin
        if (!m_err || err_clr_i) m_eaddr = cpu_addr_i;
        m_err = 1'b1;
        if (cpu_we_i == 4'h0) m_zero = mcyc + 1;
      end else begin
        if (err_clr_i) begin m_err = 1'b0; m_eaddr = 32'h0; end
        if (cpu_en_i && mcyc >= m_free && cpu_we_i == 4'h0) begin
          m_sel  = m_s;
          m_free = mcyc + lat_tab[m_s];
        end
      end
      mcyc++;
    end
  end

  always @(negedge clk_i) begin
    logic [3:0]  exp_en;
    logic [31:0] exp_dat;
    int          s;
    s       = slot(cpu_addr_i);
    exp_en  = (rst_ni && cpu_en_i && mcyc >= m_free && s >= 0) ? 4'(1 << s) : 4'h0;
    exp_dat = (!rst_ni || mcyc == m_zero) ? 32'h0 : slv_data_i[m_sel];
    chk("mdl_slv_en",   32'(slv_en_o), 32'(exp_en));
    chk("mdl_stall",    32'(stall_o),  32'(rst_ni && mcyc < m_free));
    chk("mdl_data",     cpu_data_o,    exp_dat);
    chk("mdl_err",      32'(err_o),    32'(m_err));
    chk("mdl_err_addr", err_addr_o,    m_eaddr);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; cpu_en_i = 1'b0; cpu_we_i = 4'h0; cpu_addr_i = 32'h0; err_clr_i = 1'b0;
    slv_data_i[0] = 32'h12345678;
    slv_data_i[1] = 32'hCAFEF00D;
    slv_data_i[2] = 32'h22222222;
    slv_data_i[3] = 32'hA5A5A5A5;
    tick(); tick();
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_en",    32'(slv_en_o), 32'h0);
    chk("rst_data",  cpu_data_o, 32'h0);
    chk("rst_err",   32'(err_o), 32'h0);
    chk("rst_eaddr", err_addr_o, 32'h0);
    rst_ni = 1'b1;

    // Back-to-back single-cycle reads.
    tick(); cpu_en_i = 1'b1; cpu_addr_i = 32'h01000010; #1;
    chk("rd0_en", 32'(slv_en_o), 32'h1);
    tick(); cpu_addr_i = 32'h02000000; #1;
    chk("rd0_data", cpu_data_o, 32'h12345678);
    chk("rd1_en", 32'(slv_en_o), 32'h2);
    tick(); cpu_en_i = 1'b0; #1;
    chk("rd1_data", cpu_data_o, 32'hCAFEF00D);
    chk("rd1_stall", 32'(stall_o), 32'h0);

    // Three-cycle read with the request held through the stall.
    tick(); cpu_en_i = 1'b1; cpu_addr_i = 32'h08000004; #1;
    chk("rd3_en", 32'(slv_en_o), 32'h8);
    tick(); #1;
    chk("rd3_stall1", 32'(stall_o), 32'h1);
    chk("rd3_noren", 32'(slv_en_o), 32'h0);
    tick(); #1;
    chk("rd3_stall2", 32'(stall_o), 32'h1);
    tick(); cpu_en_i = 1'b0; #1;
    chk("rd3_stall3", 32'(stall_o), 32'h0);
    chk("rd3_data", cpu_data_o, 32'hA5A5A5A5);

    // Write to the slow slave does not stall.
    tick(); cpu_en_i = 1'b1; cpu_we_i = 4'hF; cpu_addr_i = 32'h08000000; #1;
    chk("wr_en", 32'(slv_en_o), 32'h8);
    tick(); cpu_en_i = 1'b0; cpu_we_i = 4'h0; #1;
    chk("wr_stall", 32'(stall_o), 32'h0);
    chk("wr_err", 32'(err_o), 32'h0);

    // Unmapped read then unmapped write: first address held.
    tick(); cpu_en_i = 1'b1; cpu_addr_i = 32'h00000100; #1;
    chk("um_en", 32'(slv_en_o), 32'h0);
    tick(); cpu_we_i = 4'hF; cpu_addr_i = 32'h03000000; #1;
    chk("um_data", cpu_data_o, 32'h0);
    chk("um_err", 32'(err_o), 32'h1);
    tick(); cpu_en_i = 1'b0; cpu_we_i = 4'h0; #1;
    chk("um_eaddr", err_addr_o, 32'h00000100);
    tick(); err_clr_i = 1'b1;
    tick(); err_clr_i = 1'b0; #1;
    chk("clr_err", 32'(err_o), 32'h0);
    chk("clr_eaddr", err_addr_o, 32'h0);

    // Clear coinciding with a new trap: the new trap wins.
    tick(); cpu_en_i = 1'b1; cpu_we_i = 4'hF; cpu_addr_i = 32'h20000000;
    tick(); cpu_addr_i = 32'h10000000; err_clr_i = 1'b1;
    tick(); cpu_en_i = 1'b0; cpu_we_i = 4'h0; err_clr_i = 1'b0; #1;
    chk("clrwin_err", 32'(err_o), 32'h1);
    chk("clrwin_eaddr", err_addr_o, 32'h10000000);

    // Reset in the middle of a stall.
    tick(); cpu_en_i = 1'b1; cpu_addr_i = 32'h08000000;
    tick(); rst_ni = 1'b0; cpu_en_i = 1'b0; #1;
    chk("mrst_stall", 32'(stall_o), 32'h0);
    chk("mrst_en", 32'(slv_en_o), 32'h0);
    chk("mrst_data", cpu_data_o, 32'h0);
    tick(); rst_ni = 1'b1;
    tick(); cpu_en_i = 1'b1; cpu_addr_i = 32'h01000000; #1;
    chk("post_en", 32'(slv_en_o), 32'h1);
    tick(); cpu_en_i = 1'b0; #1;
    chk("post_data", cpu_data_o, 32'h12345678);
    chk("post_stall", 32'(stall_o), 32'h0);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
